// File: rtl/sdram_port_requester.sv
// Client-side initiator for the sdram controller's single request port: queues
// requests in a small FIFO, issues them one at a time and returns one response each.
module sdram_port_requester #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [BE_WIDTH-1:0]   req_byte_en,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [7:0]            error_count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] port_addr,
  output logic [DATA_WIDTH-1:0] port_data,
  output logic [BE_WIDTH-1:0]   port_byte_en,
  output logic                  port_wr,
  output logic                  port_rd,
  input  logic [DATA_WIDTH-1:0] port_q,
  input  logic                  port_available,
  input  logic                  port_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Handshakes: a transfer happens on the rising edge where valid & ready are both
  // high; valid never depends on ready, and the payload is held while valid & !ready.

  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
  logic [BE_WIDTH-1:0]   fifo_be    [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, fifo_empty;

  state_t                state_q;
  logic                  cur_write_q;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] port_addr_q;
  logic [DATA_WIDTH-1:0] port_data_q;
  logic [BE_WIDTH-1:0]   port_be_q;
  logic                  port_wr_q, port_rd_q;
  logic                  rsp_valid_q, rsp_write_q, rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [7:0]            err_cnt_q;

  // No bypass: a full FIFO refuses a push even when the head pops this cycle.
  assign req_ready  = (count_q != DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = req_valid & req_ready;
  assign pop        = (state_q == IDLE) & ~fifo_empty & port_available;
  assign tmo_d      = tmo_q + 1'b1;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr_q] <= req_write;
      fifo_addr[wr_ptr_q]  <= req_addr;
      fifo_data[wr_ptr_q]  <= req_data;
      fifo_be[wr_ptr_q]    <= req_byte_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_write_q <= 1'b0;
      tmo_q       <= '0;
      port_addr_q <= '0;
      port_data_q <= '0;
      port_be_q   <= '0;
      port_wr_q   <= 1'b0;
      port_rd_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            port_addr_q <= fifo_addr[rd_ptr_q];
            port_data_q <= fifo_data[rd_ptr_q];
            port_be_q   <= fifo_be[rd_ptr_q];
            port_wr_q   <= fifo_write[rd_ptr_q];
            port_rd_q   <= ~fifo_write[rd_ptr_q];
            cur_write_q <= fifo_write[rd_ptr_q];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          port_wr_q <= 1'b0;
          port_rd_q <= 1'b0;
          tmo_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // A completion on the limit cycle wins over the timeout.
          if (port_ready) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= cur_write_q;
            rsp_data_q  <= cur_write_q ? '0 : port_q;
            rsp_error_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_LIMIT) begin
              rsp_valid_q <= 1'b1;
              rsp_write_q <= cur_write_q;
              rsp_data_q  <= '0;
              rsp_error_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = ~fifo_empty | (state_q != IDLE);
  assign port_addr    = port_addr_q;
  assign port_data    = port_data_q;
  assign port_byte_en = port_be_q;
  assign port_wr      = port_wr_q;
  assign port_rd      = port_rd_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;
  assign error_count  = err_cnt_q;

endmodule

// File: tb/tb_sdram_port_requester.sv
// Bench for sdram_port_requester: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model and a request-order scoreboard.
`timescale 1ns/1ps
module tb_sdram_port_requester;

  localparam int AW    = 21;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } req_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [BW-1:0] req_byte_en = '0;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] port_q = '0;
  logic          port_available = 1'b1, port_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_write, rsp_error, busy, port_wr, port_rd;
  logic [DW-1:0] rsp_data, port_data;
  logic [7:0]    error_count;
  logic [AW-1:0] port_addr;
  logic [BW-1:0] port_byte_en;

  initial forever #5 clk = ~clk;

  sdram_port_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .error_count(error_count),
    .busy(busy), .port_addr(port_addr), .port_data(port_data),
    .port_byte_en(port_byte_en), .port_wr(port_wr), .port_rd(port_rd),
    .port_q(port_q), .port_available(port_available), .port_ready(port_ready)
  );

  // ---------------- counters and comparison helper ----------------
  int n_vec = 0;
  int n_bad = 0;
  int strobe_count = 0;
  int rsp_count = 0;
  bit saw_full = 0;
  bit prev_rsp_v = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted-but-unissued requests live in m_q; m_live covers one request from its
  // strobe until its response is taken.
  req_t          m_q[$];
  req_t          m_cur = '0;
  bit            m_live = 0, m_fresh = 0;
  int            m_waited = 0;
  logic          m_rsp_v = 0, m_rsp_w = 0, m_rsp_e = 0;
  logic [DW-1:0] m_rsp_d = '0;
  int            m_errs = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [BW-1:0] m_be = '0;
  logic [AW-1:0] exp_q[$];

  task automatic model_step();
    req_t nr;
    bit   do_push;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_live = 0; m_fresh = 0; m_waited = 0;
      m_rsp_v = 0; m_rsp_w = 0; m_rsp_e = 0; m_rsp_d = '0;
      m_errs = 0; m_addr = '0; m_data = '0; m_be = '0;
      armed = 1;
      return;
    end
    do_push = req_valid && (m_q.size() < DEPTH);
    nr = '{req_write, req_addr, req_data, req_byte_en};
    if (m_rsp_v) begin
      if (rsp_ready) begin m_rsp_v = 0; m_live = 0; end
    end else if (m_live) begin
      if (m_fresh) begin
        m_fresh = 0; m_waited = 0;
      end else if (port_ready) begin
        m_rsp_v = 1; m_rsp_w = m_cur.w; m_rsp_e = 0;
        m_rsp_d = m_cur.w ? '0 : port_q;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_rsp_v = 1; m_rsp_w = m_cur.w; m_rsp_e = 1; m_rsp_d = '0;
          if (m_errs < 255) m_errs++;
        end
      end
    end else if (m_q.size() != 0 && port_available) begin
      m_cur = m_q.pop_front();
      m_live = 1; m_fresh = 1;
      m_addr = m_cur.a; m_data = m_cur.d; m_be = m_cur.be;
    end
    if (do_push) begin
      m_q.push_back(nr);
      exp_q.push_back(nr.a);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("req_ready", req_ready, m_q.size() < DEPTH);
      chk("busy", busy, (m_q.size() != 0) || m_live);
      chk("port_wr", port_wr, m_fresh && m_cur.w);
      chk("port_rd", port_rd, m_fresh && !m_cur.w);
      chk("port_addr", port_addr, m_addr);
      chk("port_data", port_data, m_data);
      chk("port_byte_en", port_byte_en, m_be);
      chk("rsp_valid", rsp_valid, m_rsp_v);
      if (m_rsp_v) begin
        chk("rsp_write", rsp_write, m_rsp_w);
        chk("rsp_data", rsp_data, m_rsp_d);
        chk("rsp_error", rsp_error, m_rsp_e);
      end
      chk("error_count", error_count, m_errs);
    end
    if (!req_ready) saw_full = 1;
    if (port_wr || port_rd) begin
      strobe_count++;
      chk("strobe_has_request", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("strobe_order", port_addr, exp_q.pop_front());
    end
    if (rsp_valid && !prev_rsp_v) rsp_count++;
    prev_rsp_v = rsp_valid;
  end

  // ---------------- controller responder ----------------
  logic [DW-1:0] mem [int];
  int            cd = 0;
  int            ctrl_lat = 4;
  bit            ctrl_mute = 0, ctrl_rand = 0;
  bit            cur_rd = 0;
  logic [DW-1:0] rd_word = '0;

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 31));
    if (r == 0) return 0;
    if (r == 1) return TMO;
    if (r == 2) return TMO + 1;
    return int'($urandom_range(1, 6));
  endfunction

  initial forever begin
    int            lat;
    logic [DW-1:0] w;
    @(negedge clk);
    port_ready = 1'b0;
    port_q     = $urandom();
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        port_ready = 1'b1;
        if (cur_rd) port_q = rd_word;
      end
    end
    if (port_wr || port_rd) begin
      if (port_wr) begin
        w = mem.exists(int'(port_addr)) ? mem[int'(port_addr)] : '0;
        for (int b = 0; b < BW; b++)
          if (port_byte_en[b]) w[8*b +: 8] = port_data[8*b +: 8];
        mem[int'(port_addr)] = w;
      end
      cur_rd  = port_rd;
      rd_word = mem.exists(int'(port_addr)) ? mem[int'(port_addr)] : '0;
      lat = ctrl_rand ? pick_lat() : ctrl_lat;
      if (!ctrl_mute && lat > 0) cd = lat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    bit acc = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d; req_byte_en = be;
    for (int t = 0; t < 2000 && !acc; t++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!acc) chk("send_req_timeout", req_ready, 1);
  endtask

  task automatic wait_rsp(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      if (rsp_valid) return;
      tick();
    end
    chk("wait_rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_strobe(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      if (port_wr || port_rd) return;
      tick();
    end
    chk("wait_strobe_timeout", port_wr || port_rd, 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      if (!busy && !rsp_valid) return;
      tick();
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int  s0, r0, n;
    bit  prod_done;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_port_wr", port_wr, 0);
    chk("rst_port_addr", port_addr, 0);

    // single write
    ctrl_lat = 4; s0 = strobe_count;
    send_req(1'b1, 21'h002020, 32'h0000_1234, 4'hF);
    tick();
    chk("min_latency_wr", port_wr, 1);
    wait_rsp(50);
    chk("t1_rsp_write", rsp_write, 1);
    chk("t1_rsp_error", rsp_error, 0);
    chk("t1_rsp_data", rsp_data, 0);
    chk("t1_addr_held", port_addr, 21'h002020);
    chk("t1_strobes", strobe_count - s0, 1);
    wait_idle(50);

    // read back
    ctrl_lat = 3; s0 = strobe_count;
    send_req(1'b0, 21'h002020, 32'hDEAD_BEEF, 4'h0);
    wait_rsp(50);
    chk("t3_rsp_data", rsp_data, 32'h0000_1234);
    chk("t3_rsp_write", rsp_write, 0);
    chk("t3_strobes", strobe_count - s0, 1);
    wait_idle(50);

    // back-to-back burst into a slow controller
    ctrl_lat = 6; saw_full = 0; s0 = strobe_count; r0 = rsp_count;
    for (int i = 0; i < 8; i++)
      send_req(1'b1, 21'h002020 + 21'(i), (i == 7) ? 32'h3210 : 32'h1234 + 32'(i), 4'hF);
    wait_idle(400);
    chk("t2_saw_full", saw_full, 1);
    chk("t2_strobes", strobe_count - s0, 8);
    chk("t2_responses", rsp_count - r0, 8);

    // controller unavailable
    ctrl_lat = 3; port_available = 1'b0; s0 = strobe_count;
    send_req(1'b0, 21'h002021, 32'h0, 4'h0);
    send_req(1'b0, 21'h002022, 32'h0, 4'h0);
    repeat (50) tick();
    chk("t4_no_strobe", strobe_count - s0, 0);
    chk("t4_error_count", error_count, 0);
    chk("t4_busy", busy, 1);
    port_available = 1'b1;
    tick();
    chk("t4_first_strobe", port_rd, 1);
    wait_rsp(30);
    chk("t4_rsp_data", rsp_data, 32'h0000_1235);
    wait_idle(100);

    // timeout, then the limit-cycle completion boundary
    ctrl_mute = 1;
    send_req(1'b1, 21'h002030, 32'h0000_AAAA, 4'h3);
    wait_strobe(20);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("t5_timeout_lat", n, 17);
    chk("t5_rsp_error", rsp_error, 1);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_error_count", error_count, 1);
    wait_idle(20);
    ctrl_mute = 0; ctrl_lat = TMO;
    send_req(1'b0, 21'h002030, 32'h0, 4'h0);
    wait_rsp(60);
    chk("t5_limit_rsp_error", rsp_error, 0);
    chk("t5_limit_rsp_data", rsp_data, 32'h0000_AAAA);
    chk("t5_limit_error_count", error_count, 1);
    wait_idle(20);

    // stalled response, then reset during the next WAIT
    rsp_ready = 1'b0; ctrl_lat = 2;
    send_req(1'b1, 21'h002040, 32'h5555_0000, 4'hC);
    send_req(1'b0, 21'h002041, 32'h0, 4'h0);
    wait_rsp(30);
    s0 = strobe_count;
    repeat (10) begin
      tick();
      chk("t6_hold_valid", rsp_valid, 1);
      chk("t6_hold_write", rsp_write, 1);
      chk("t6_hold_data", rsp_data, 0);
    end
    chk("t6_hold_no_strobe", strobe_count - s0, 0);
    ctrl_lat = 8; rsp_ready = 1'b1;
    wait_strobe(10);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    s0 = strobe_count; r0 = rsp_count;
    repeat (12) begin
      tick();
      chk("t6_post_rst_rsp_valid", rsp_valid, 0);
    end
    chk("t6_post_rst_busy", busy, 0);
    chk("t6_post_rst_req_ready", req_ready, 1);
    chk("t6_post_rst_error_count", error_count, 0);
    chk("t6_post_rst_port_addr", port_addr, 0);
    chk("t6_post_rst_responses", rsp_count - r0, 0);
    chk("t6_post_rst_strobes", strobe_count - s0, 0);

    // randomized traffic
    ctrl_rand = 1; prod_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_req(1'($urandom_range(0, 1)), 21'h002000 + 21'($urandom_range(0, 15)),
                   $urandom(), 4'($urandom_range(0, 15)));
        end
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          rsp_ready      = ($urandom_range(0, 3) != 0);
          port_available = ($urandom_range(0, 7) != 0);
          tick();
        end
      end
    join
    rsp_ready = 1'b1; port_available = 1'b1; ctrl_rand = 0; ctrl_lat = 2;
    wait_idle(500);
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
